// File: rtl/univ_shift_reg_pkg.sv
// Shared types and constants for the universal shift register and its controllers.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SHR  = 2'd1,
    SHL  = 2'd2,
    LOAD = 2'd3
  } shift_mode_t;

  localparam int unsigned ShiftModeCount = 4;

  function automatic logic is_shift(input shift_mode_t m);
    return (m == SHR) || (m == SHL);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle between a shift-register controller (master) and the register (slave).
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    import shift_reg_pkg::*;

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic              en;
    shift_mode_t       mode;
    logic              sin_r;
    logic              sin_l;
    logic [WIDTH-1:0]  d;
    logic [WIDTH-1:0]  q;
    logic              sout_r;
    logic              sout_l;
    logic [CntW-1:0]   cnt;
    logic              done;

    modport master (
        output en, mode, sin_r, sin_l, d,
        input  q, sout_r, sout_l, cnt, done
    );

    modport slave (
        input  en, mode, sin_r, sin_l, d,
        output q, sout_r, sout_l, cnt, done
    );

endinterface

// File: rtl/univ_shift_reg_bit_counter.sv
// Saturating shift counter with a one-cycle pulse on the step that reaches MAX.
module shift_bit_counter #(
    parameter int unsigned MAX  = 8,
    parameter int unsigned CntW = $clog2(MAX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            clr_i,
    output logic [CntW-1:0] cnt_o,
    output logic            done_o
);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CntW'(MAX))) begin
            cnt_d  = cnt_q + CntW'(1);
            done_d = (cnt_q == CntW'(MAX - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift right, shift left, parallel load,
// with shift counting and a word-complete pulse for serdes use.
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    univ_shift_reg_if.slave        bus_io
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             inc, clr;
    logic [CntW-1:0]  cnt;
    logic             done;

    always_comb begin
        q_d = q_q;
        inc = 1'b0;
        clr = 1'b0;
        if (bus_io.en) begin
            unique case (bus_io.mode)
                HOLD: ;
                SHR: begin
                    q_d = {bus_io.sin_r, q_q[WIDTH-1:1]};
                    inc = 1'b1;
                end
                SHL: begin
                    q_d = {q_q[WIDTH-2:0], bus_io.sin_l};
                    inc = 1'b1;
                end
                LOAD: begin
                    q_d = bus_io.d;
                    clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    shift_bit_counter #(
        .MAX  (WIDTH),
        .CntW (CntW)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (inc),
        .clr_i  (clr),
        .cnt_o  (cnt),
        .done_o (done)
    );

    assign bus_io.q      = q_q;
    assign bus_io.sout_r = q_q[0];
    assign bus_io.sout_l = q_q[WIDTH-1];
    assign bus_io.cnt    = cnt;
    assign bus_io.done   = done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg against an arithmetic reference model.
module tb_univ_shift_reg;
    import shift_reg_pkg::*;

    localparam int unsigned W  = 8;
    localparam logic [7:0]  RV = 8'h3C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(W)) bus ();

    univ_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (RV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: register value, unsaturated shift count since LOAD/reset, done flag.
    logic [7:0] m_q;
    int         m_n;
    logic       m_done;

    function automatic logic [3:0] exp_cnt();
        return (m_n > int'(W)) ? 4'(W) : 4'(m_n);
    endfunction

    task automatic step(input logic r, input logic e, input shift_mode_t md,
                        input logic sr, input logic sl, input logic [7:0] dd);
        rst       = r;
        bus.en    = e;
        bus.mode  = md;
        bus.sin_r = sr;
        bus.sin_l = sl;
        bus.d     = dd;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (!r) begin
            m_q = RV;
            m_n = 0;
        end else if (e) begin
            if (md == SHR) begin
                m_q = (m_q >> 1) + (sr ? 8'h80 : 8'h00);
                m_n++;
                m_done = (m_n == int'(W));
            end else if (md == SHL) begin
                m_q = 8'((m_q << 1) + {7'd0, sl});
                m_n++;
                m_done = (m_n == int'(W));
            end else if (md == LOAD) begin
                m_q = dd;
                m_n = 0;
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, HOLD, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, SHR, 1'b1, 1'b1, 8'hFF);
        n_checks++;
        if ({bus.q, bus.cnt, bus.done, bus.sout_r, bus.sout_l} !== {8'h3C, 4'd0, 3'b000})
            $display("FAIL reset: got q=%h cnt=%0d done=%b sr=%b sl=%b, want q=3c cnt=0 done=0 sr=0 sl=0",
                     bus.q, bus.cnt, bus.done, bus.sout_r, bus.sout_l);
        else n_pass++;
    endtask

    task automatic test_serialize_right();
        logic [7:0] pat = 8'hA5;
        int dones = 0;
        step(1'b1, 1'b1, LOAD, 1'b0, 1'b0, pat);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.sout_r !== pat[i])
                $display("FAIL ser_sout_r[%0d]: got %b want %b", i, bus.sout_r, pat[i]);
            else n_pass++;
            step(1'b1, 1'b1, SHR, 1'b1, 1'b0, 8'h00);
            if (bus.done === 1'b1) dones++;
            n_checks++;
            if ({bus.q, bus.cnt, bus.done} !== {m_q, exp_cnt(), m_done})
                $display("FAIL ser_model: got q=%h cnt=%0d done=%b want q=%h cnt=%0d done=%b",
                         bus.q, bus.cnt, bus.done, m_q, exp_cnt(), m_done);
            else n_pass++;
        end
        step(1'b1, 1'b1, HOLD, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({bus.q, bus.cnt, bus.done, 4'(dones)} !== {8'hFF, 4'd8, 1'b0, 4'd1})
            $display("FAIL ser_final: got q=%h cnt=%0d done=%b pulses=%0d want q=ff cnt=8 done=0 pulses=1",
                     bus.q, bus.cnt, bus.done, dones);
        else n_pass++;
    endtask

    task automatic test_shift_left_saturate();
        int dones = 0;
        step(1'b1, 1'b1, LOAD, 1'b0, 1'b0, 8'h81);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, SHL, 1'b1, 1'b0, 8'h00);
            if (bus.done === 1'b1) dones++;
            n_checks++;
            if ({bus.q, bus.cnt, bus.done} !== {m_q, exp_cnt(), m_done})
                $display("FAIL shl_model[%0d]: got q=%h cnt=%0d done=%b want q=%h cnt=%0d done=%b",
                         i, bus.q, bus.cnt, bus.done, m_q, exp_cnt(), m_done);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (bus.q !== 8'h02) $display("FAIL shl_first: got q=%h want 02", bus.q);
                else n_pass++;
            end
        end
        n_checks++;
        if ({bus.q, bus.cnt, 4'(dones)} !== {8'h00, 4'd8, 4'd1})
            $display("FAIL shl_final: got q=%h cnt=%0d pulses=%0d want q=00 cnt=8 pulses=1",
                     bus.q, bus.cnt, dones);
        else n_pass++;
    endtask

    task automatic test_enable_hold();
        step(1'b1, 1'b1, LOAD, 1'b0, 1'b0, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(1'b1, 1'b0, SHR, 1'b1, 1'b1, 8'($urandom));
            else       step(1'b1, 1'b1, HOLD, 1'b1, 1'b1, 8'($urandom));
            n_checks++;
            if ({bus.q, bus.cnt, bus.done} !== {8'h5A, 4'd0, 1'b0})
                $display("FAIL en_hold[%0d]: got q=%h cnt=%0d done=%b want q=5a cnt=0 done=0",
                         i, bus.q, bus.cnt, bus.done);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        step(1'b1, 1'b1, LOAD, 1'b0, 1'b0, 8'hF0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, SHR, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, SHR, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if ({bus.q, bus.cnt, bus.done} !== {RV, 4'd0, 1'b0})
            $display("FAIL rst_mid: got q=%h cnt=%0d done=%b want q=%h cnt=0 done=0",
                     bus.q, bus.cnt, bus.done, RV);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, SHR, (i % 2 == 0), 1'b0, 8'h00);
            if (bus.done === 1'b1) dones++;
        end
        n_checks++;
        if ({bus.q, bus.cnt, 4'(dones)} !== {8'h55, 4'd8, 4'd1})
            $display("FAIL deser: got q=%h cnt=%0d pulses=%0d want q=55 cnt=8 pulses=1",
                     bus.q, bus.cnt, dones);
        else n_pass++;
    endtask

    task automatic test_mixed_load_during_done();
        step(1'b1, 1'b1, LOAD, 1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, (i < 4) ? SHR : SHL, 1'($urandom), 1'($urandom), 8'h00);
            n_checks++;
            if (bus.done !== (i == 7))
                $display("FAIL mixed_done[%0d]: got done=%b want %b", i, bus.done, (i == 7));
            else n_pass++;
        end
        step(1'b1, 1'b1, LOAD, 1'b0, 1'b0, 8'h11);
        n_checks++;
        if ({bus.q, bus.cnt, bus.done} !== {8'h11, 4'd0, 1'b0})
            $display("FAIL load_in_done: got q=%h cnt=%0d done=%b want q=11 cnt=0 done=0",
                     bus.q, bus.cnt, bus.done);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0),
                 shift_mode_t'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom));
            n_checks++;
            if ({bus.q, bus.cnt, bus.done, bus.sout_r, bus.sout_l} !==
                {m_q, exp_cnt(), m_done, m_q[0], m_q[7]}) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random[%0d]: got q=%h cnt=%0d done=%b want q=%h cnt=%0d done=%b",
                             i, bus.q, bus.cnt, bus.done, m_q, exp_cnt(), m_done);
            end else n_pass++;
        end
    endtask

    initial begin
        m_q    = RV;
        m_n    = 0;
        m_done = 1'b0;
        test_reset();
        test_serialize_right();
        test_shift_left_saturate();
        test_enable_hold();
        test_reset_mid();
        test_mixed_load_during_done();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
